// File: rtl/mac_issue_ctrl.sv
// ============================================================================
// mac_issue_ctrl : issues key (load) then query (execute) vectors to MAC column 0
//                  and counts returned psums to signal run completion.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac_issue_ctrl #(
  parameter int bw         = 8,
  parameter int pr         = 8,
  parameter int addr_bw    = 6,
  parameter int load_len   = 10,
  parameter int q_len      = 8,
  parameter int key_base   = 0,
  parameter int query_base = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 mem_cen,
  output logic [addr_bw-1:0]   mem_addr,
  input  logic [pr*bw-1:0]     mem_dout,
  output logic [pr*bw-1:0]     q_out,
  output logic [1:0]           o_inst,
  input  logic                 fifo_wr_in,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           rd_cnt
);

  localparam int IW = $clog2(((load_len > q_len) ? load_len : q_len) + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]    inst_q, inst_d;
  logic [3:0]    cnt_q, cnt_d, cnt_inc;
  logic          done_q, done_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    inst_d   = 2'b00;
    mem_cen  = 1'b1;
    mem_addr = '0;
    // Saturating psum count; the DRAIN exit check sees this cycle's pulse.
    cnt_inc  = (fifo_wr_in && (cnt_q < 4'(q_len))) ? cnt_q + 4'd1 : cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        mem_cen  = 1'b0;
        mem_addr = addr_bw'(key_base) + addr_bw'(idx_q);
        inst_d   = 2'b01;
        cnt_d    = cnt_inc;
        if (idx_q == IW'(load_len - 1)) begin
          state_d = ST_EXEC;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_EXEC: begin
        mem_cen  = 1'b0;
        mem_addr = addr_bw'(query_base) + addr_bw'(idx_q);
        inst_d   = 2'b10;
        cnt_d    = cnt_inc;
        if (idx_q == IW'(q_len - 1)) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_inc;
        if (cnt_inc == 4'(q_len)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      inst_q  <= 2'b00;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Read data arrives one cycle after the read, together with its instruction.
  assign q_out  = mem_dout;
  assign o_inst = inst_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign rd_cnt = cnt_q;

endmodule

`default_nettype wire
